// File: rtl/seg7_pkg.sv
// Shared constants for the BCD scan display: slot encoding, glyphs and anode values.
package seg7_pkg;

    // Scan slot index; the encoding 2'd3 is unused and recovers to SlotOnes.
    typedef enum logic [1:0] {
        SlotOnes     = 2'd0,
        SlotTens     = 2'd1,
        SlotHundreds = 2'd2
    } slot_e;

    // Active-low gfedcba glyphs (bit 0 = segment a).
    localparam logic [6:0] Glyph0     = 7'h40;
    localparam logic [6:0] Glyph1     = 7'h79;
    localparam logic [6:0] Glyph2     = 7'h24;
    localparam logic [6:0] Glyph3     = 7'h30;
    localparam logic [6:0] Glyph4     = 7'h19;
    localparam logic [6:0] Glyph5     = 7'h12;
    localparam logic [6:0] Glyph6     = 7'h02;
    localparam logic [6:0] Glyph7     = 7'h78;
    localparam logic [6:0] Glyph8     = 7'h00;
    localparam logic [6:0] Glyph9     = 7'h10;
    localparam logic [6:0] GlyphDash  = 7'h3F;
    localparam logic [6:0] GlyphBlank = 7'h7F;

    localparam logic [2:0] AnOff = 3'b111;

    // Anode pattern that lights only the digit for the given slot.
    function automatic logic [2:0] an_select(input slot_e slot);
        logic [2:0] an;
        case (slot)
            SlotOnes:     an = 3'b110;
            SlotTens:     an = 3'b101;
            SlotHundreds: an = 3'b011;
            default:      an = AnOff;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// Digit inputs and multiplexed display outputs of the BCD scan display.
interface bcd_scan_display_if;

    logic       load;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       blank_lz;
    logic [2:0] an_n;
    logic [6:0] seg_n;

    // Upstream converter / stimulus side.
    modport master (
        output load, hundreds, tens, ones, blank_lz,
        input  an_n, seg_n
    );

    // Display stage side.
    modport slave (
        input  load, hundreds, tens, ones, blank_lz,
        output an_n, seg_n
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] glyph_o
);

    // Map each BCD code to its glyph, invalid codes to the dash.
    always_comb begin
        glyph_o = GlyphDash;
        case (code_i)
            4'd0:    glyph_o = Glyph0;
            4'd1:    glyph_o = Glyph1;
            4'd2:    glyph_o = Glyph2;
            4'd3:    glyph_o = Glyph3;
            4'd4:    glyph_o = Glyph4;
            4'd5:    glyph_o = Glyph5;
            4'd6:    glyph_o = Glyph6;
            4'd7:    glyph_o = Glyph7;
            4'd8:    glyph_o = Glyph8;
            4'd9:    glyph_o = Glyph9;
            default: glyph_o = GlyphDash;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Three-digit time-multiplexed seven-segment driver with guard blanking and
// optional leading-zero suppression. All outputs come straight from flops.
module bcd_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_scan_display_if.slave  bus
);

    localparam int unsigned    CntW     = $clog2(REFRESH_DIV);
    localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] GuardCnt = CntW'(GUARD);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wrap;
    slot_e           slot_q, slot_d;
    logic [11:0]     disp_q, disp_d;
    logic [3:0]      digit;
    logic [6:0]      glyph;
    logic            h_zero, t_zero;
    logic            blank_slot, in_guard, slot_valid;
    logic [2:0]      an_d, an_q;
    logic [6:0]      seg_d, seg_q;

    // Slot divider: free-running modulo REFRESH_DIV counter.
    always_comb begin
        wrap  = (cnt_q == CntMax);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    // Slot index FSM: ones -> tens -> hundreds -> ones on each divider wrap.
    always_comb begin
        slot_d = slot_q;
        case (slot_q)
            SlotOnes:     if (wrap) slot_d = SlotTens;
            SlotTens:     if (wrap) slot_d = SlotHundreds;
            SlotHundreds: if (wrap) slot_d = SlotOnes;
            default:      slot_d = SlotOnes;
        endcase
    end

    // Display register captures all three digits on load only.
    always_comb begin
        disp_d = disp_q;
        if (bus.load) begin
            disp_d = {bus.hundreds, bus.tens, bus.ones};
        end
    end

    // Select the digit for the current slot; one shared decoder follows.
    always_comb begin
        digit = disp_q[3:0];
        case (slot_q)
            SlotTens:     digit = disp_q[7:4];
            SlotHundreds: digit = disp_q[11:8];
            default:      digit = disp_q[3:0];
        endcase
    end

    seg7_decode u_decode (
        .code_i  (digit),
        .glyph_o (glyph)
    );

    // Blanking: guard window, suppressed leading zeros, and the unused slot code.
    // Only a literal zero counts; invalid codes are shown as a dash.
    always_comb begin
        h_zero     = (disp_q[11:8] == 4'd0);
        t_zero     = (disp_q[7:4] == 4'd0);
        in_guard   = (cnt_q < GuardCnt);
        slot_valid = (an_select(slot_q) != AnOff);
        blank_slot = bus.blank_lz &&
                     (((slot_q == SlotHundreds) && h_zero) ||
                      ((slot_q == SlotTens) && h_zero && t_zero));
        an_d  = AnOff;
        seg_d = GlyphBlank;
        if (!in_guard && !blank_slot && slot_valid) begin
            an_d  = an_select(slot_q);
            seg_d = glyph;
        end
    end

    // State and output registers; reset blanks the display at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            slot_q <= SlotOnes;
            disp_q <= '0;
            an_q   <= AnOff;
            seg_q  <= GlyphBlank;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            disp_q <= disp_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign bus.an_n  = an_q;
    assign bus.seg_n = seg_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display with REFRESH_DIV=8, GUARD=2.
module tb_bcd_scan_display;

    localparam int unsigned RefreshDiv = 8;
    localparam int unsigned Guard      = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bcd_scan_display_if bus ();

    bcd_scan_display #(
        .REFRESH_DIV (RefreshDiv),
        .GUARD       (Guard)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One scan test: digits, suppression flag, expected per-slot outputs
    // (index 0 = ones, 1 = tens, 2 = hundreds).
    typedef struct packed {
        logic [3:0]       h;
        logic [3:0]       t;
        logic [3:0]       o;
        logic             blz;
        logic [2:0][6:0]  seg;
        logic [2:0][2:0]  an;
    } vec_t;

    localparam int NumVec = 9;
    vec_t vecs [NumVec];

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    function automatic vec_t mk(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                                input logic blz,
                                input logic [6:0] s_o, input logic [2:0] a_o,
                                input logic [6:0] s_t, input logic [2:0] a_t,
                                input logic [6:0] s_h, input logic [2:0] a_h);
        vec_t v;
        v.h = h; v.t = t; v.o = o; v.blz = blz;
        v.seg[0] = s_o; v.an[0] = a_o;
        v.seg[1] = s_t; v.an[1] = a_t;
        v.seg[2] = s_h; v.an[2] = a_h;
        return v;
    endfunction

    task automatic check(input string name, input logic [2:0] exp_an, input logic [6:0] exp_seg);
        n_tests++;
        if (bus.an_n !== exp_an || bus.seg_n !== exp_seg) begin
            n_fail++;
            $display("FAIL %s: got an_n=%b seg_n=0x%h, expected an_n=%b seg_n=0x%h",
                     name, bus.an_n, bus.seg_n, exp_an, exp_seg);
        end
    endtask

    // Advance to the falling edge that follows rising edge number e.
    task automatic to_edge(input int e);
        while (edge_n < e) begin
            @(negedge clk);
            edge_n++;
        end
    endtask

    // Reset, then load the digits on the first edge after release.
    task automatic reset_and_load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                                  input logic blz);
        rst_n        = 1'b0;
        bus.load     = 1'b1;
        bus.hundreds = h;
        bus.tens     = t;
        bus.ones     = o;
        bus.blank_lz = blz;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        edge_n   = 1;
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.hundreds = 4'd0;
        bus.tens     = 4'd0;
        bus.ones     = 4'd0;
        bus.blank_lz = 1'b0;

        //                h      t      o      blz   ones          tens          hundreds
        vecs[0] = mk(4'd0,  4'd0,  4'd0,  1'b0, 7'h40, 3'b110, 7'h40, 3'b101, 7'h40, 3'b011);
        vecs[1] = mk(4'd1,  4'd2,  4'd3,  1'b1, 7'h30, 3'b110, 7'h24, 3'b101, 7'h79, 3'b011);
        vecs[2] = mk(4'd0,  4'd0,  4'd7,  1'b1, 7'h78, 3'b110, 7'h7F, 3'b111, 7'h7F, 3'b111);
        vecs[3] = mk(4'd0,  4'd0,  4'd7,  1'b0, 7'h78, 3'b110, 7'h40, 3'b101, 7'h40, 3'b011);
        vecs[4] = mk(4'd0,  4'd12, 4'd5,  1'b1, 7'h12, 3'b110, 7'h3F, 3'b101, 7'h7F, 3'b111);
        vecs[5] = mk(4'd4,  4'd5,  4'd6,  1'b0, 7'h02, 3'b110, 7'h12, 3'b101, 7'h19, 3'b011);
        vecs[6] = mk(4'd15, 4'd8,  4'd0,  1'b1, 7'h40, 3'b110, 7'h00, 3'b101, 7'h3F, 3'b011);
        vecs[7] = mk(4'd0,  4'd0,  4'd0,  1'b1, 7'h40, 3'b110, 7'h7F, 3'b111, 7'h7F, 3'b111);
        vecs[8] = mk(4'd0,  4'd7,  4'd9,  1'b1, 7'h10, 3'b110, 7'h78, 3'b101, 7'h7F, 3'b111);

        @(negedge clk);

        // Full scan per vector, plus the first guard and digit of the next scan.
        for (int i = 0; i < NumVec; i++) begin
            rst_n        = 1'b0;
            bus.load     = 1'b1;
            bus.hundreds = vecs[i].h;
            bus.tens     = vecs[i].t;
            bus.ones     = vecs[i].o;
            bus.blank_lz = vecs[i].blz;
            @(negedge clk);
            check($sformatf("v%0d_in_reset", i), 3'b111, 7'h7F);
            rst_n = 1'b1;
            for (int k = 1; k <= 27; k++) begin
                int c;
                int s;
                @(negedge clk);
                if (k == 1) begin
                    bus.load = 1'b0;
                end
                c = (k - 1) % 8;
                s = ((k - 1) / 8) % 3;
                if (c < 2) begin
                    check($sformatf("v%0d_e%0d_guard", i, k), 3'b111, 7'h7F);
                end else begin
                    check($sformatf("v%0d_e%0d_slot%0d", i, k, s), vecs[i].an[s], vecs[i].seg[s]);
                end
            end
        end

        // Mid-slot load at divider=4, then a load coinciding with the wrap.
        reset_and_load(4'd0, 4'd0, 4'd0, 1'b0);
        to_edge(4);
        bus.hundreds = 4'd9; bus.tens = 4'd9; bus.ones = 4'd9; bus.load = 1'b1;
        to_edge(5);
        bus.load = 1'b0;
        check("midload_old", 3'b110, 7'h40);
        to_edge(6);
        check("midload_new", 3'b110, 7'h10);
        to_edge(8);
        check("midload_slot_end", 3'b110, 7'h10);
        to_edge(9);
        check("midload_guard0", 3'b111, 7'h7F);
        to_edge(10);
        check("midload_guard1", 3'b111, 7'h7F);
        to_edge(11);
        check("midload_tens", 3'b101, 7'h10);
        to_edge(15);
        bus.hundreds = 4'd1; bus.tens = 4'd2; bus.ones = 4'd3; bus.load = 1'b1;
        to_edge(16);
        bus.load = 1'b0;
        check("wrapload_tens_tail", 3'b101, 7'h10);
        to_edge(17);
        check("wrapload_guard0", 3'b111, 7'h7F);
        to_edge(18);
        check("wrapload_guard1", 3'b111, 7'h7F);
        to_edge(19);
        check("wrapload_hundreds", 3'b011, 7'h79);

        // Toggling blank_lz takes effect one edge later.
        reset_and_load(4'd0, 4'd0, 4'd7, 1'b1);
        to_edge(3);
        check("lz_ones", 3'b110, 7'h78);
        to_edge(11);
        check("lz_tens_blank", 3'b111, 7'h7F);
        bus.blank_lz = 1'b0;
        to_edge(12);
        check("lz_tens_shown", 3'b101, 7'h40);
        to_edge(19);
        check("lz_hundreds_shown", 3'b011, 7'h40);
        bus.blank_lz = 1'b1;
        to_edge(20);
        check("lz_hundreds_blank", 3'b111, 7'h7F);

        // Reset in the tens slot blanks without a clock edge and restarts at ones.
        reset_and_load(4'd4, 4'd5, 4'd6, 1'b0);
        to_edge(12);
        check("rst_tens_before", 3'b101, 7'h12);
        rst_n = 1'b0;
        #1;
        check("rst_async", 3'b111, 7'h7F);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        to_edge(2);
        check("rst_guard", 3'b111, 7'h7F);
        to_edge(3);
        check("rst_ones_zero", 3'b110, 7'h40);
        to_edge(11);
        check("rst_tens_zero", 3'b101, 7'h40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Sequential display stage directly downstream of the binary-to-BCD converter. It captures the three BCD digits (hundreds, tens, ones) on a load strobe and time-multiplexes them onto a three-digit, common-anode, active-low seven-segment display. It provides a refresh divider, anti-ghosting guard blanking, optional leading-zero suppression, and a dash glyph for invalid BCD codes. All outputs are registered and glitch-free.

## Interface
- REFRESH_DIV, 100000: clock cycles per digit slot; legal range ≥ 4.
- GUARD, 16: cycles at the start of each slot with all anodes off; legal range 1 ≤ GUARD < REFRESH_DIV.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  when high, capture hundreds/tens/ones into the display register on this edge.
- hundreds  in  4  BCD hundreds digit.
- tens  in  4  BCD tens digit.
- ones  in  4  BCD ones digit.
- blank_lz  in  1  leading-zero suppression enable; sampled every cycle, not latched.
- an_n  out  3  active-low anode enables; [0]=ones, [1]=tens, [2]=hundreds.
- seg_n  out  7  active-low segments, bit order gfedcba (seg_n[0]=a).

## Operation
- Display register: 12 bits {h,t,o}. Reset value 0. Written only on a cycle with load=1. Inputs are ignored otherwise.
- Divider: counts 0..REFRESH_DIV-1 and wraps to 0. At the wrap, the slot index advances ones→tens→hundreds→ones.
- Slot index: 2-bit state with values ONES=0, TENS=1, HUNDREDS=2. Value 3 is unreachable; if it is ever reached, the next cycle forces ONES.
- Guard: while divider < GUARD, an_n=3'b111 and seg_n=7'h7F.
- Digit decode (active-low gfedcba): 0→0x40, 1→0x79, 2→0x24, 3→0x30, 4→0x19, 5→0x12, 6→0x02, 7→0x78, 8→0x00, 9→0x10, 10–15→dash 0x3F.
- Leading-zero suppression (blank_lz=1):
  - Hundreds slot is blank when h==0.
  - Tens slot is blank when h==0 and t==0.
  - Ones slot is never blank.
  - Invalid codes (≥10) are never treated as zero.
- Blank slot: an_n=3'b111 and seg_n=7'h7F for the entire slot.
- Active slot after the guard: exactly one an_n bit is low (the bit for the current index), and seg_n carries that digit's glyph.
- A load arriving mid-slot does not disturb the divider or the slot index.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by system): an_n=3'b111, seg_n=7'h7F, divider=0, index=ONES, display register=0.
- After reset release, the first GUARD cycles are guard. The ones slot then shows 0x40 with an_n=3'b110.
- Output latency: an_n/seg_n are registered from the divider, index, display register and blank_lz.
  - A load sampled at edge N is visible on the outputs after edge N+1.
  - A change of blank_lz is also visible one edge later.
- Slot boundary: the wrap at edge N changes the index; the outputs after edge N+1 are guard values.
- The full scan period is 3·REFRESH_DIV cycles.
- If load coincides with the divider wrap, both take effect. The new slot shows new data once its guard expires.
- Reset asserted mid-slot: outputs are forced to reset values immediately (no clock needed), and scanning restarts at ONES.

## Structure
- Package seg7_pkg:
  - slot index encoding constants (ONES/TENS/HUNDREDS);
  - glyph constants for 0–9, DASH=0x3F and BLANK=0x7F;
  - an_n off value 3'b111.
- Sub-module seg7_decode: purely combinational, 4-bit code → 7-bit active-low glyph, including the dash for 10–15. It is instantiated once, on the muxed digit.
- Top-level contents: divider, index FSM, display register, blanking logic, output registers.

## Test plan
Use REFRESH_DIV=8 and GUARD=2 for all scenarios.
- Reset → an_n=3'b111, seg_n=0x7F during reset. After release: 2 guard cycles, then 6 cycles of an_n=3'b110 / seg_n=0x40.
- load with 1,2,3 and blank_lz=1 → slot sequence:
  - ones: an_n=110, seg_n=0x30;
  - tens: an_n=101, seg_n=0x24;
  - hundreds: an_n=011, seg_n=0x79;
  - each slot preceded by 2 cycles of an_n=111.
- load with 0,0,7 and blank_lz=1 → ones shows 0x78; tens and hundreds slots are an_n=111 throughout. Toggle blank_lz=0 → the next tens/hundreds slots show 0x40.
- load with 0,12,5 and blank_lz=1 → tens shows dash 0x3F (not blanked); hundreds is blanked; ones shows 0x12.
- load pulse mid-slot (divider=4, value 9,9,9) → outputs change one edge later to 0x10; the slot boundary timing is unchanged.
- Assert rst_n low during the tens slot → outputs go to 3'b111/0x7F with no clock edge. After release, scanning restarts at ones with data 0.
